data_memory_subword: RTL and testbench
======================================

# data_memory_subword

Parametrised successor to the lab data memory: a word-organised MIPS data RAM with byte, halfword and word access, sign or zero extension on loads, and a registered read. It also performs a post-reset clear sweep. It sits in the MEM stage between the ALU result (address) and the write-back mux, and serves lb/lbu/lh/lhu/lw/sb/sh/sw.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- ADDR_WIDTH, 32: byte-address width.
- CLEAR_ON_RESET, 1: 1 means zero-fill the array after reset; 0 means no sweep and contents are undefined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request, sampled each edge.
- mem_write  in  1  store request, sampled each edge.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
- address  in  ADDR_WIDTH  byte address.
- write_data  in  32  store data; sub-word stores use the low bits.
- read_data  out  32  extended load result.
- read_valid  out  1  one-cycle pulse; read_data is new this cycle.
- busy  out  1  clear sweep in progress; all requests are ignored.
- access_err  out  1  one-cycle pulse for a rejected request.

## Operation
- Byte lanes are big-endian. Offset 0 is bits [31:24], offset 3 is [7:0]. Halfword offset 0 is [31:16].
- Word index is address[log2(DEPTH_WORDS)+1:2].
- Request is legal when all of these hold:
  - !busy;
  - size != 11;
  - the access is aligned (half needs addr[0]=0, word needs addr[1:0]=0);
  - address < 4*DEPTH_WORDS.
- Legal store: only the selected lanes are written at the sampling edge; other lanes keep their value.
- Legal load: the selected lanes are extracted, right-justified and extended per sign_ext. Word loads ignore sign_ext.
- Illegal request (mem_read or mem_write set while not busy):
  - no array write;
  - read_valid stays 0;
  - read_data holds;
  - access_err pulses.
- Requests while busy are dropped silently; access_err stays 0.
- mem_read and mem_write together, legal: both happen. The load returns the pre-store contents (read-first).
- States:
  - RESET: while rst=1.
  - CLEAR: entered on the first edge with rst=0 when CLEAR_ON_RESET=1. A counter writes zero to word 0 through DEPTH_WORDS-1, one word per cycle.
  - READY: entered after the last word is cleared, or directly from RESET when CLEAR_ON_RESET=0.
- Reset during CLEAR, in any state, returns to RESET. The sweep then restarts from word 0.

## Timing
- Values while rst=1, and on the first edge after it deasserts:
  - read_data = 0;
  - read_valid = 0;
  - access_err = 0;
  - busy = CLEAR_ON_RESET.
- busy stays high for exactly DEPTH_WORDS cycles after rst deasserts, then falls.
- Load latency is 1 cycle. A request sampled at edge N gives read_data/read_valid after edge N and holds them until edge N+1.
- A store at edge N is visible to a load sampled at edge N+1.
- access_err is registered and appears 1 cycle after the offending edge.
- Back-to-back loads run at one per cycle; read_valid stays high continuously.

## Structure
- Package data_mem_pkg holds:
  - the SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_RSVD constants;
  - the state encoding (RESET, CLEAR, READY).
- Sub-module data_mem_lane_unit is purely combinational. From size, addr[1:0] and write_data it produces the 4-bit lane enable and the replicated store word. From the raw word it produces the extracted, extended load value.
- The top level holds the array, the clear counter/FSM and the output registers.

## Test plan
- Reset sweep: hold rst for 3 cycles, release with DEPTH_WORDS=16. busy must be high for 16 cycles. A lw of address 0x3C must then return 0x00000000.
- Sub-word store/load:
  - sw 0x11223344 @0x10, then sb 0xAB @0x11, then lw @0x10 must give 0x11AB3344.
  - lb @0x11 must give 0xFFFFFFAB; lbu must give 0x000000AB.
- Halfword: sh 0x8001 @0x22, then lh @0x22 must give 0xFFFF8001 and lhu must give 0x00008001. Word 0x20 must show 0x8001 in bits [15:0].
- Errors, each followed by a check that memory is unchanged:
  - lw @0x06 must pulse access_err with no read_valid.
  - sh @0x03 must pulse access_err.
  - size=11 must pulse access_err.
  - lw @4*DEPTH_WORDS must pulse access_err.
- Simultaneous access: word 0x8 holds 0x0, then read and write 0xDEADBEEF to it in the same cycle. Load must return 0x0, and the next lw must return 0xDEADBEEF.
- Reset mid-sweep: assert rst at clear cycle 5, release. busy must last another full DEPTH_WORDS cycles. A request during busy must produce no read_valid and no access_err.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants for the sub-word data memory: access size codes and
// the controller state encoding.
package data_mem_pkg;

  // Access size codes carried on the size port
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Controller states
  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

endpackage

// File: rtl/data_mem_lane_unit.sv
// Combinational byte-lane steering for a big-endian 32-bit word.
// Lane i means bits [8*i+7:8*i]; byte offset 0 is lane 3 (bits [31:24]).
module data_mem_lane_unit
  import data_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] write_data,
  input  logic [31:0] raw_word,
  output logic [3:0]  lane_en,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword out of the raw word
  always_comb begin
    sel_byte = raw_word[31:24];
    case (addr_lo)
      2'd0:    sel_byte = raw_word[31:24];
      2'd1:    sel_byte = raw_word[23:16];
      2'd2:    sel_byte = raw_word[15:8];
      default: sel_byte = raw_word[7:0];
    endcase
    sel_half = addr_lo[1] ? raw_word[15:0] : raw_word[31:16];
  end

  // Store side: lane enables and the store data replicated across lanes,
  // so every enabled lane simply takes its own slice of store_word
  always_comb begin
    lane_en    = 4'b0000;
    store_word = write_data;
    case (size)
      SIZE_BYTE: begin
        lane_en    = 4'b1000 >> addr_lo;
        store_word = {4{write_data[7:0]}};
      end
      SIZE_HALF: begin
        lane_en    = addr_lo[1] ? 4'b0011 : 4'b1100;
        store_word = {2{write_data[15:0]}};
      end
      SIZE_WORD: begin
        lane_en    = 4'b1111;
        store_word = write_data;
      end
      default: begin
        lane_en    = 4'b0000;
        store_word = write_data;
      end
    endcase
  end

  // Load side: right-justify the selected lanes and extend; words ignore sign_ext
  always_comb begin
    load_word = raw_word;
    case (size)
      SIZE_BYTE: load_word = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_word = {{16{sign_ext & sel_half[15]}}, sel_half};
      default:   load_word = raw_word;
    endcase
  end

endmodule

// File: rtl/data_memory_subword.sv
// MEM-stage data RAM with byte/half/word access, registered read,
// read-first behaviour on simultaneous load+store, and a post-reset
// zero-fill sweep during which all requests are dropped.
//
// Handshake: mem_read/mem_write are sampled every rising edge with no
// back-pressure other than busy. A legal load sampled at edge N drives
// read_data with read_valid=1 for the single cycle after edge N; a
// rejected request pulses access_err for the cycle after its edge and
// leaves read_data unchanged. While busy=1 requests produce no response.
module data_memory_subword
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  access_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [1:0]       state;
  logic [IDX_W-1:0] clr_cnt;

  logic             sweeping;
  logic             accept;
  logic             aligned;
  logic             in_range;
  logic             legal;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      raw_word;
  logic [3:0]       lane_en;
  logic [31:0]      store_word;
  logic [31:0]      load_word;

  // The sweep writes one word per edge starting on the first edge out of
  // reset, so busy covers exactly DEPTH_WORDS cycles after rst falls.
  assign sweeping = (CLEAR_ON_RESET != 0) && !rst &&
                    ((state == ST_RESET) || (state == ST_CLEAR));
  assign busy     = (CLEAR_ON_RESET != 0) && (state != ST_READY);
  assign accept   = !busy && !rst;

  assign word_idx = address[IDX_W+1:2];
  assign raw_word = mem[word_idx];
  assign in_range = ({1'b0, address} < BYTE_LIMIT);

  // Alignment rule per access size
  always_comb begin
    aligned = 1'b1;
    case (size)
      SIZE_HALF: aligned = !address[0];
      SIZE_WORD: aligned = (address[1:0] == 2'b00);
      default:   aligned = 1'b1;
    endcase
  end

  assign legal = (size != SIZE_RSVD) && aligned && in_range;

  data_mem_lane_unit u_lane (
    .size       (size),
    .addr_lo    (address[1:0]),
    .sign_ext   (sign_ext),
    .write_data (write_data),
    .raw_word   (raw_word),
    .lane_en    (lane_en),
    .store_word (store_word),
    .load_word  (load_word)
  );

  // Controller: RESET -> CLEAR -> READY, or RESET -> READY without a sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
    end else if (sweeping) begin
      clr_cnt <= clr_cnt + 1'b1;
      state   <= (clr_cnt == LAST_IDX) ? ST_READY : ST_CLEAR;
    end else begin
      case (state)
        ST_RESET: state <= ST_READY;
        ST_CLEAR: state <= ST_READY;
        default:  state <= ST_READY;
      endcase
    end
  end

  // Array writes: zero fill during the sweep, lane-masked stores otherwise
  always_ff @(posedge clk) begin
    if (sweeping) begin
      mem[clr_cnt] <= 32'h0;
    end else if (accept && legal && mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  // Registered load result and single-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= 32'h0;
      read_valid <= 1'b0;
      access_err <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      access_err <= 1'b0;
      if (accept && (mem_read || mem_write)) begin
        if (!legal) begin
          access_err <= 1'b1;
        end else if (mem_read) begin
          read_valid <= 1'b1;
          read_data  <= load_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_subword.sv
// Directed bench for data_memory_subword (16 words, sweep enabled).
// Stimulus pushes expected responses into exp_q; a monitor pops them
// whenever the DUT shows read_valid or access_err.
module tb_data_memory_subword;
  import data_mem_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = SIZE_WORD;
  logic        sign_ext = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        busy;
  logic        access_err;

  // bit 32 set means an access_err pulse is expected instead of a load result
  logic [32:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;
  int          total_cnt = 0;
  int          pass_cnt = 0;

  data_memory_subword #(
    .DEPTH_WORDS    (DEPTH),
    .ADDR_WIDTH     (32),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .sign_ext   (sign_ext),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .busy       (busy),
    .access_err (access_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [32:0] e;
    if (read_valid === 1'b1 || access_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got read_valid=%0b access_err=%0b required none",
                 read_valid, access_err);
      end else begin
        e = exp_q.pop_front();
        if (e[32]) begin
          check("err_pulse", {30'h0, read_valid, access_err}, 32'h1);
          check("err_rd_hold", read_data, last_rd);
        end else begin
          check("load_pulse", {30'h0, read_valid, access_err}, 32'h2);
          check("load_data", read_data, e[31:0]);
          last_rd = e[31:0];
        end
      end
    end
  end

  // driver tasks: each starts at a negedge and holds inputs for one edge
  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    size       = sz;
    sign_ext   = sx;
    address    = addr;
    write_data = wd;
  endtask

  task automatic load(input logic [1:0] sz, input logic sx, input logic [31:0] addr,
                      input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, sx, addr, 32'h0);
    exp_q.push_back({1'b0, exp});
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    drive(1'b0, 1'b1, sz, 1'b0, addr, wd);
  endtask

  task automatic bad(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] wd);
    drive(rd, wr, sz, 1'b0, addr, wd);
    exp_q.push_back({1'b1, 32'h0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  // Called at a negedge: drops rst and counts cycles with busy high,
  // optionally issuing a load every busy cycle.
  task automatic release_and_count(input logic poke, output int n);
    n = 0;
    rst = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (poke) begin
        mem_read = 1'b1;
        size     = SIZE_WORD;
        address  = 32'h10;
      end
      @(negedge clk);
    end
    mem_read = 1'b0;
  endtask

  initial begin
    int n;

    // reset sweep
    repeat (3) @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_read_valid", {31'h0, read_valid}, 32'h0);
    check("rst_access_err", {31'h0, access_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
    release_and_count(1'b0, n);
    check("sweep_busy_cycles", n, DEPTH);
    load(SIZE_WORD, 1'b0, 32'h3C, 32'h0000_0000);

    // sub-word store/load
    store(SIZE_WORD, 32'h10, 32'h1122_3344);
    store(SIZE_BYTE, 32'h11, 32'h0000_00AB);
    load(SIZE_WORD, 1'b0, 32'h10, 32'h11AB_3344);
    load(SIZE_BYTE, 1'b1, 32'h11, 32'hFFFF_FFAB);
    load(SIZE_BYTE, 1'b0, 32'h11, 32'h0000_00AB);
    load(SIZE_BYTE, 1'b1, 32'h10, 32'h0000_0011);
    load(SIZE_BYTE, 1'b0, 32'h12, 32'h0000_0033);
    load(SIZE_BYTE, 1'b1, 32'h13, 32'h0000_0044);
    load(SIZE_HALF, 1'b1, 32'h10, 32'h0000_11AB);
    load(SIZE_HALF, 1'b0, 32'h12, 32'h0000_3344);
    load(SIZE_WORD, 1'b1, 32'h10, 32'h11AB_3344);

    // halfword
    store(SIZE_HALF, 32'h22, 32'h0000_8001);
    load(SIZE_HALF, 1'b1, 32'h22, 32'hFFFF_8001);
    load(SIZE_HALF, 1'b0, 32'h22, 32'h0000_8001);
    load(SIZE_WORD, 1'b0, 32'h20, 32'h0000_8001);

    // errors, each followed by an unchanged-memory check
    bad(1'b1, 1'b0, SIZE_WORD, 32'h06, 32'h0);
    load(SIZE_WORD, 1'b0, 32'h04, 32'h0000_0000);
    bad(1'b0, 1'b1, SIZE_HALF, 32'h03, 32'h0000_5555);
    load(SIZE_WORD, 1'b0, 32'h00, 32'h0000_0000);
    bad(1'b0, 1'b1, SIZE_RSVD, 32'h10, 32'hFFFF_FFFF);
    load(SIZE_WORD, 1'b0, 32'h10, 32'h11AB_3344);
    bad(1'b1, 1'b0, SIZE_WORD, 32'h40, 32'h0);
    bad(1'b0, 1'b1, SIZE_WORD, 32'h40, 32'hCAFE_F00D);
    load(SIZE_WORD, 1'b0, 32'h00, 32'h0000_0000);

    // simultaneous load+store is read-first
    load(SIZE_WORD, 1'b0, 32'h08, 32'h0000_0000);
    drive(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h08, 32'hDEAD_BEEF);
    exp_q.push_back({1'b0, 32'h0000_0000});
    load(SIZE_WORD, 1'b0, 32'h08, 32'hDEAD_BEEF);
    idle(3);
    check("queue_drained_1", exp_q.size(), 0);

    // reset in the middle of the sweep restarts it
    rst = 1'b1;
    last_rd = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midsweep_rst_busy", {31'h0, busy}, 32'h1);
    release_and_count(1'b1, n);
    check("midsweep_busy_cycles", n, DEPTH);
    load(SIZE_WORD, 1'b0, 32'h10, 32'h0000_0000);
    load(SIZE_WORD, 1'b0, 32'h08, 32'h0000_0000);
    idle(3);
    check("queue_drained_2", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
